// File: rtl/class_train_ctrl.sv
// ---------------------------------------------------------------------------
// class_train_ctrl
//
// Sequences one training session of a hyperdimensional classifier.
// Labelled sample hypervectors are steered into a per-class accumulator
// bank, and each class is limited to SPC samples. When the quota is full, or
// finalize arrives, the thresholded class vector of every class is read back
// and streamed out in class order.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   start                     begin a session (honoured in IDLE only)
//   finalize                  end training early (honoured in TRAIN only)
//   s_valid/s_ready           sample input handshake
//   s_class, s_hv             sample label and hypervector
//   acc_clr                   one-cycle clear pulse to the accumulator bank
//   acc_en, acc_class, acc_hv accumulate strobe, target bank and vector
//   rd_en, rd_class           thresholded-vector read request
//   rd_hv                     read data, valid one cycle after rd_en
//   m_valid/m_ready           class-vector output handshake
//   m_class, m_hv             output class label and hypervector
//   busy                      session in progress (state != IDLE)
//   done                      one-cycle end-of-session pulse
//   err_class                 one-cycle pulse for a dropped sample
// ---------------------------------------------------------------------------
module class_train_ctrl #(
  parameter int NUM_CLASSES = 26,
  parameter int DIM         = 10,
  parameter int SPC         = 240,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             finalize,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [4:0]       s_class,
  input  logic [DIM-1:0]   s_hv,
  output logic             acc_clr,
  output logic             acc_en,
  output logic [4:0]       acc_class,
  output logic [DIM-1:0]   acc_hv,
  output logic             rd_en,
  output logic [4:0]       rd_class,
  input  logic [DIM-1:0]   rd_hv,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [4:0]       m_class,
  output logic [DIM-1:0]   m_hv,
  output logic             busy,
  output logic             done,
  output logic             err_class
);

  localparam int TOTAL = NUM_CLASSES * SPC;
  localparam int TOT_W = $clog2(TOTAL + 1);
  localparam logic [TOT_W-1:0] TOTAL_C  = TOT_W'(TOTAL);
  localparam logic [CNT_W-1:0] SPC_C    = CNT_W'(SPC);
  localparam logic [4:0]       LAST_IDX = 5'(NUM_CLASSES - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, TRAIN, DRAIN, READ, CAPTURE, EMIT, DONE
  } state_t;

  state_t state, state_next;

  logic [4:0]       idx;
  logic [CNT_W-1:0] count [NUM_CLASSES];
  logic [TOT_W-1:0] total;
  logic [CNT_W-1:0] sel_count;
  logic             class_ok;
  logic             accept;
  logic             sample_ok;
  logic             last_sample;

  // Look up the running count of the incoming label. Labels outside the
  // class range select nothing and are rejected through class_ok.
  always_comb begin
    sel_count = '0;
    class_ok  = int'(s_class) < NUM_CLASSES;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (int'(s_class) == i) sel_count = count[i];
    end
    accept      = (state == TRAIN) && s_valid;
    sample_ok   = accept && class_ok && (sel_count < SPC_C);
    last_sample = sample_ok && (total == TOTAL_C - TOT_W'(1));
  end

  // Next-state logic and state-decoded strobes.
  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    acc_clr    = 1'b0;
    rd_en      = 1'b0;
    rd_class   = '0;
    m_valid    = 1'b0;
    busy       = (state != IDLE);
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = CLEAR;
      end
      CLEAR: begin
        acc_clr    = 1'b1;
        state_next = TRAIN;
      end
      TRAIN: begin
        s_ready = 1'b1;
        // A sample that arrives together with finalize is still processed;
        // DRAIN gives its accumulate strobe a cycle to commit.
        if (finalize || last_sample) state_next = DRAIN;
      end
      DRAIN: begin
        state_next = READ;
      end
      READ: begin
        rd_en      = 1'b1;
        rd_class   = idx;
        state_next = CAPTURE;
      end
      CAPTURE: begin
        state_next = EMIT;
      end
      EMIT: begin
        m_valid = 1'b1;
        if (m_ready) state_next = (idx == LAST_IDX) ? DONE : READ;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus every registered output, counter and index.
  // Reset clears everything, so no strobe survives the reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      total     <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) count[i] <= '0;
      acc_en    <= 1'b0;
      acc_class <= '0;
      acc_hv    <= '0;
      err_class <= 1'b0;
      m_class   <= '0;
      m_hv      <= '0;
    end else begin
      state     <= state_next;
      acc_en    <= sample_ok;
      err_class <= accept && !sample_ok;

      if (sample_ok) begin
        acc_class <= s_class;
        acc_hv    <= s_hv;
        total     <= total + TOT_W'(1);
        for (int i = 0; i < NUM_CLASSES; i++) begin
          if (int'(s_class) == i) count[i] <= count[i] + CNT_W'(1);
        end
      end

      case (state)
        CLEAR: begin
          total <= '0;
          idx   <= '0;
          for (int i = 0; i < NUM_CLASSES; i++) count[i] <= '0;
        end
        DRAIN: idx <= '0;
        CAPTURE: begin
          m_hv    <= rd_hv;
          m_class <= idx;
        end
        EMIT: begin
          if (m_ready && (idx != LAST_IDX)) idx <= idx + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
